// File: rtl/ft245_fifo_responder_pkg.sv
// ft245_fifo_responder_pkg
// Shared definitions for the FT245 FIFO responder: FSM state encoding,
// data bus width and a small helper used to size the access counter.
package ft245_fifo_responder_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACCESS = 2'd1,
    RD_DRIVE  = 2'd2,
    PRECHARGE = 2'd3
  } state_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ft245_fifo_responder_fifo.sv
// ft245_fifo_responder_fifo
// Synchronous byte FIFO with exact occupancy. Pointers carry one extra bit
// so a full FIFO (level == 2^DEPTH_LOG2) is distinguishable from empty.
// Push while full and pop while empty are ignored; push and pop in the same
// cycle are both performed.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   push_i, pushData_i    write request and byte
//   pop_i, popData_o      read request and head byte (valid when !empty_o)
//   full_o, empty_o       status flags
//   level_o               occupancy 0..2^DEPTH_LOG2
module ft245_fifo_responder_fifo
  import ft245_fifo_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [BUS_W-1:0]      pushData_i,
  input  logic                  pop_i,
  output logic [BUS_W-1:0]      popData_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [BUS_W-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2:0] rdPtr_q, rdPtr_d;
  logic                doPush, doPop;

  assign level_o   = wrPtr_q - rdPtr_q;
  assign full_o    = (level_o == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o   = (wrPtr_q == rdPtr_q);
  assign doPush    = push_i & ~full_o;
  assign doPop     = pop_i & ~empty_o;
  assign popData_o = mem_q[rdPtr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q + (DEPTH_LOG2+1)'(doPush);
    rdPtr_d = rdPtr_q + (DEPTH_LOG2+1)'(doPop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q[DEPTH_LOG2-1:0]] <= pushData_i;
    end
  end

endmodule

// File: rtl/ft245_fifo_responder.sv
// ft245_fifo_responder
// Device-side model of an FT245 asynchronous FIFO. Presents rxf_n/txe_n to a
// bus controller, answers its rd_n/wr_n strobes and owns the data bus while a
// read is being served. The host side is a pair of valid/ready byte streams.
// Optional feature macro: FT245_RESP_LOOPBACK_EN -- when defined, bytes written
// by the controller are moved straight back into the read FIFO and the host
// stream ports are inert.
// Ports:
//   in_clk, in_reset_n                 clock, asynchronous active-low reset
//   io_ftdi_data                       FT245 data bus (driven only in RD_DRIVE)
//   out_ftdi_rxf_n / out_ftdi_txe_n    read-available / write-space flags
//   in_ftdi_rd_n / in_ftdi_wr_n        controller strobes, active low
//   in_host_data/valid, out_host_ready host -> RX FIFO stream
//   out_host_data/valid, in_host_ready TX FIFO -> host stream
//   out_rx_level / out_tx_level        FIFO occupancies
//   out_proto_err, in_err_clr          sticky protocol error and its clear
module ft245_fifo_responder
  import ft245_fifo_responder_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RD_ACCESS_CYC = 2,
  parameter int PRECHARGE_CYC = 3
) (
  input  logic                     in_clk,
  input  logic                     in_reset_n,
  inout  wire  [BUS_W-1:0]         io_ftdi_data,
  output logic                     out_ftdi_rxf_n,
  output logic                     out_ftdi_txe_n,
  input  logic                     in_ftdi_rd_n,
  input  logic                     in_ftdi_wr_n,
  input  logic [BUS_W-1:0]         in_host_data,
  input  logic                     in_host_valid,
  output logic                     out_host_ready,
  output logic [BUS_W-1:0]         out_host_data,
  output logic                     out_host_valid,
  input  logic                     in_host_ready,
  output logic [RX_DEPTH_LOG2:0]   out_rx_level,
  output logic [TX_DEPTH_LOG2:0]   out_tx_level,
  output logic                     out_proto_err,
  input  logic                     in_err_clr
);

  localparam int CNT_W = $clog2(maxInt(RD_ACCESS_CYC, PRECHARGE_CYC) + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdN_q, wrN_q;
  logic             rxfN_q, rxfN_d;
  logic             txeN_q, txeN_d;
  logic             protoErr_q, protoErr_d;

  logic             rdFall, rdRise, wrFall;
  logic             errNow, rxPop, txPush, busDrive;
  logic             rxPush, txPop;
  logic [BUS_W-1:0] rxPushData, rxHead, txHead;
  logic             rxFull, rxEmpty, txFull, txEmpty;

  assign rdFall = rdN_q & ~in_ftdi_rd_n;
  assign rdRise = ~rdN_q & in_ftdi_rd_n;
  assign wrFall = wrN_q & ~in_ftdi_wr_n;

  // The bus is let go in the very cycle rd_n returns high, and immediately
  // when reset asserts, since state_q is asynchronously forced to IDLE.
  assign busDrive     = (state_q == RD_DRIVE) & ~rdRise;
  assign io_ftdi_data = busDrive ? rxHead : {BUS_W{1'bz}};

  ft245_fifo_responder_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) uRxFifo (
    .clk_i      (in_clk),
    .rst_ni     (in_reset_n),
    .push_i     (rxPush),
    .pushData_i (rxPushData),
    .pop_i      (rxPop),
    .popData_o  (rxHead),
    .full_o     (rxFull),
    .empty_o    (rxEmpty),
    .level_o    (out_rx_level)
  );

  ft245_fifo_responder_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) uTxFifo (
    .clk_i      (in_clk),
    .rst_ni     (in_reset_n),
    .push_i     (txPush),
    .pushData_i (io_ftdi_data),
    .pop_i      (txPop),
    .popData_o  (txHead),
    .full_o     (txFull),
    .empty_o    (txEmpty),
    .level_o    (out_tx_level)
  );

`ifdef FT245_RESP_LOOPBACK_EN
  logic unusedHost;
  assign unusedHost     = ^{in_host_data, in_host_valid, in_host_ready};
  assign rxPush         = ~txEmpty & ~rxFull;
  assign rxPushData     = txHead;
  assign txPop          = rxPush;
  assign out_host_ready = 1'b0;
  assign out_host_valid = 1'b0;
  assign out_host_data  = '0;
`else
  assign rxPush         = in_host_valid;
  assign rxPushData     = in_host_data;
  assign txPop          = in_host_ready;
  assign out_host_ready = ~rxFull;
  assign out_host_valid = ~txEmpty;
  assign out_host_data  = txHead;
`endif

  // Next-state logic. A read fall wins over a simultaneous write fall; a
  // write is only accepted while rd_n is high so overlapping strobes never
  // touch the TX FIFO. rxf_n/txe_n are derived from the next state so they
  // are high for exactly the cycles the FSM spends outside IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rxPop   = 1'b0;
    txPush  = 1'b0;
    errNow  = (rdFall & rxfN_q) | (wrFall & txeN_q) |
              (~in_ftdi_rd_n & ~in_ftdi_wr_n);
    case (state_q)
      IDLE: begin
        if (rdFall && !rxfN_q) begin
          state_d = RD_ACCESS;
          cnt_d   = CNT_W'(RD_ACCESS_CYC);
        end else if (wrFall && !txeN_q && in_ftdi_rd_n) begin
          txPush  = 1'b1;
          state_d = PRECHARGE;
          cnt_d   = CNT_W'(PRECHARGE_CYC);
        end
      end
      RD_ACCESS: begin
        if (rdRise) begin
          errNow  = 1'b1;
          state_d = PRECHARGE;
          cnt_d   = CNT_W'(PRECHARGE_CYC);
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = RD_DRIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_DRIVE: begin
        if (rdRise) begin
          rxPop   = 1'b1;
          state_d = PRECHARGE;
          cnt_d   = CNT_W'(PRECHARGE_CYC);
        end
      end
      default: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
    rxfN_d     = ~((state_d == IDLE) & ~rxEmpty);
    txeN_d     = ~((state_d == IDLE) & ~txFull);
    protoErr_d = errNow ? 1'b1 : (in_err_clr ? 1'b0 : protoErr_q);
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdN_q      <= 1'b1;
      wrN_q      <= 1'b1;
      rxfN_q     <= 1'b1;
      txeN_q     <= 1'b1;
      protoErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdN_q      <= in_ftdi_rd_n;
      wrN_q      <= in_ftdi_wr_n;
      rxfN_q     <= rxfN_d;
      txeN_q     <= txeN_d;
      protoErr_q <= protoErr_d;
    end
  end

  assign out_ftdi_rxf_n = rxfN_q;
  assign out_ftdi_txe_n = txeN_q;
  assign out_proto_err  = protoErr_q;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// tb_ft245_fifo_responder
// Self-checking bench: directed scenarios with literal expectations, then
// randomized strobe/host traffic compared every cycle against a
// transaction-level model built from queues and event cycle numbers.
// The bus carries a pull-up, so a released bus reads 8'hFF.
module tb_ft245_fifo_responder;

  localparam int RD  = 2;
  localparam int PC  = 3;
  localparam int RXD = 16;
  localparam int TXD = 16;

  logic       clk;
  logic       rstN;
  logic       rdN, wrN;
  logic [7:0] hostData;
  logic       hostValid, hostReady, errClr;
  logic [7:0] tbBusData;
  wire  [7:0] ftdiBus;
  logic       rxfN, txeN, hostReadyO, hostValidO, protoErr;
  logic [7:0] hostDataO;
  logic [4:0] rxLevel, txLevel;

  int checks = 0;
  int errors = 0;

  // The bench only drives the bus for a write with rd_n high, which the
  // responder never overlaps with its own read drive.
  assign ftdiBus = (!wrN && rdN) ? tbBusData : 8'bz;
  pullup (ftdiBus);

  ft245_fifo_responder #(
    .RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4),
    .RD_ACCESS_CYC(RD), .PRECHARGE_CYC(PC)
  ) dut (
    .in_clk         (clk),
    .in_reset_n     (rstN),
    .io_ftdi_data   (ftdiBus),
    .out_ftdi_rxf_n (rxfN),
    .out_ftdi_txe_n (txeN),
    .in_ftdi_rd_n   (rdN),
    .in_ftdi_wr_n   (wrN),
    .in_host_data   (hostData),
    .in_host_valid  (hostValid),
    .out_host_ready (hostReadyO),
    .out_host_data  (hostDataO),
    .out_host_valid (hostValidO),
    .in_host_ready  (hostReady),
    .out_rx_level   (rxLevel),
    .out_tx_level   (txLevel),
    .out_proto_err  (protoErr),
    .in_err_clr     (errClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO contents as queues; the device's activity as the
  // edge number at which a read strobe fell and the edge from which it is
  // idle again.
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit mRdPrev, mWrPrev, mReadActive, mRxf, mTxe, mErr;
  int mReadFall, mIdleFrom, mCyc;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    int c = mCyc + 1;
    bit rdF, rdR, wrF, idleBefore, idleAfter, drivingBefore, err;
    bit rxHad, rxFullPre, txFullPre, txHad, popRx, pushTx, hostPush, hostPop, loopMove;
    logic [7:0] txHeadPre;
    rdF = mRdPrev && !rdN;
    rdR = !mRdPrev && rdN;
    wrF = mWrPrev && !wrN;
    idleBefore    = !mReadActive && (c > mIdleFrom);
    drivingBefore = mReadActive && ((c - 1) >= mReadFall + RD);
    err = (rdF && mRxf) || (wrF && mTxe) || (!rdN && !wrN);
    popRx = 0;
    pushTx = 0;
    rxHad     = rxq.size() > 0;
    rxFullPre = rxq.size() >= RXD;
    txHad     = txq.size() > 0;
    txFullPre = txq.size() >= TXD;
    txHeadPre = txHad ? txq[0] : 8'h00;
    if (mReadActive) begin
      if (rdR) begin
        if (drivingBefore) popRx = 1;
        else err = 1;
        mReadActive = 0;
        mIdleFrom = c + PC;
      end
    end else if (idleBefore) begin
      if (rdF && !mRxf) begin
        mReadActive = 1;
        mReadFall = c;
      end else if (wrF && !mTxe && rdN) begin
        pushTx = 1;
        mIdleFrom = c + PC;
      end
    end
    idleAfter = !mReadActive && (c >= mIdleFrom);
    mRxf = !(idleAfter && rxHad);
    mTxe = !(idleAfter && !txFullPre);
    mErr = err ? 1'b1 : (errClr ? 1'b0 : mErr);
`ifdef FT245_RESP_LOOPBACK_EN
    loopMove = txHad && !rxFullPre;
    hostPush = 0;
    hostPop  = 0;
`else
    loopMove = 0;
    hostPush = hostValid && !rxFullPre;
    hostPop  = hostReady && txHad;
`endif
    if (popRx) void'(rxq.pop_front());
    if (loopMove || hostPop) void'(txq.pop_front());
    if (hostPush) rxq.push_back(hostData);
    if (loopMove) rxq.push_back(txHeadPre);
    if (pushTx) txq.push_back(tbBusData);
    mRdPrev = rdN;
    mWrPrev = wrN;
    mCyc = c;
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxq.delete();
      txq.delete();
      mRdPrev = 1; mWrPrev = 1; mRxf = 1; mTxe = 1; mErr = 0;
      mReadActive = 0; mReadFall = 0; mIdleFrom = 0; mCyc = 0;
    end else begin
      modelStep();
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    bit expDrive;
    if (rstN) begin
      expDrive = mReadActive && (mCyc >= mReadFall + RD) && !(!mRdPrev && rdN);
      checkOutput("rxf_n", rxfN, mRxf);
      checkOutput("txe_n", txeN, mTxe);
      checkOutput("proto_err", protoErr, mErr);
      checkOutput("rx_level", rxLevel, rxq.size());
      checkOutput("tx_level", txLevel, txq.size());
`ifdef FT245_RESP_LOOPBACK_EN
      checkOutput("host_ready", hostReadyO, 0);
      checkOutput("host_valid", hostValidO, 0);
`else
      checkOutput("host_ready", hostReadyO, rxq.size() < RXD);
      checkOutput("host_valid", hostValidO, txq.size() > 0);
      if (txq.size() > 0) checkOutput("host_data", hostDataO, txq[0]);
`endif
      if (!(rdN && !wrN))
        checkOutput("bus", ftdiBus, (expDrive && rxq.size() > 0) ? rxq[0] : 8'hFF);
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitRxfLow();
    int n = 0;
    while (rxfN !== 1'b0 && n < 50) begin nextCycle(); n++; end
    checkOutput("rxf_wait", rxfN, 1'b0);
  endtask

  task automatic waitTxeLow();
    int n = 0;
    while (txeN !== 1'b0 && n < 50) begin nextCycle(); n++; end
    checkOutput("txe_wait", txeN, 1'b0);
  endtask

  task automatic busWrite(input logic [7:0] d);
    waitTxeLow();
    tbBusData = d;
    wrN = 1'b0;
    nextCycle();
    nextCycle();
    wrN = 1'b1;
  endtask

  task automatic pushHost(input logic [7:0] d);
    hostData = d;
    hostValid = 1'b1;
    nextCycle();
    hostValid = 1'b0;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) rdN = ~rdN;
      if ($urandom_range(0, 5) == 0) begin
        wrN = ~wrN;
        if (!wrN) tbBusData = 8'($urandom);
      end
      hostValid = 1'($urandom_range(0, 1));
      hostData  = 8'($urandom);
      hostReady = ($urandom_range(0, 2) == 0);
      errClr    = ($urandom_range(0, 19) == 0);
      nextCycle();
    end
    rdN = 1; wrN = 1; hostValid = 0; hostReady = 0; errClr = 0;
    repeat (8) nextCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 0; rdN = 1; wrN = 1; hostData = 0; hostValid = 0;
    hostReady = 0; errClr = 0; tbBusData = 0;
    #23 rstN = 1;
    nextCycle();
    $display("[TB] reset release");
    checkOutput("rst_txe_n", txeN, 1'b0);
    checkOutput("rst_rxf_n", rxfN, 1'b1);
    checkOutput("rst_bus", ftdiBus, 8'hFF);
    checkOutput("rst_rx_level", rxLevel, 0);
    checkOutput("rst_tx_level", txLevel, 0);
    checkOutput("rst_err", protoErr, 1'b0);
    checkOutput("rst_host_valid", hostValidO, 1'b0);

`ifdef FT245_RESP_LOOPBACK_EN
    $display("[TB] loopback write then read");
    busWrite(8'h55);
    waitRxfLow();
    checkOutput("lb_rx_level", rxLevel, 1);
    checkOutput("lb_tx_level", txLevel, 0);
    checkOutput("lb_host_valid", hostValidO, 1'b0);
    rdN = 0;
    repeat (RD + 1) nextCycle();
    checkOutput("lb_bus", ftdiBus, 8'h55);
    repeat (2) nextCycle();
    rdN = 1;
    nextCycle();
    checkOutput("lb_rx_after", rxLevel, 0);
`else
    $display("[TB] single read of 0xA5");
    pushHost(8'hA5);
    checkOutput("a5_rx_level", rxLevel, 1);
    checkOutput("a5_rxf_early", rxfN, 1'b1);
    waitRxfLow();
    rdN = 0;
    nextCycle();
    checkOutput("a5_rxf_busy", rxfN, 1'b1);
    nextCycle();
    checkOutput("a5_bus_access", ftdiBus, 8'hFF);
    nextCycle();
    checkOutput("a5_bus_drive", ftdiBus, 8'hA5);
    nextCycle();
    nextCycle();
    rdN = 1;
    #1;
    checkOutput("a5_bus_release", ftdiBus, 8'hFF);
    nextCycle();
    checkOutput("a5_rx_after", rxLevel, 0);
    checkOutput("a5_pre1", txeN, 1'b1);
    nextCycle();
    checkOutput("a5_pre2", txeN, 1'b1);
    nextCycle();
    checkOutput("a5_pre3", txeN, 1'b1);
    nextCycle();
    checkOutput("a5_idle", txeN, 1'b0);

    $display("[TB] two controller writes");
    busWrite(8'h3C);
    busWrite(8'hC3);
    nextCycle();
    checkOutput("wr_tx_level", txLevel, 2);
    checkOutput("wr_head0", hostDataO, 8'h3C);
    hostReady = 1;
    nextCycle();
    checkOutput("wr_head1", hostDataO, 8'hC3);
    checkOutput("wr_tx_level1", txLevel, 1);
    nextCycle();
    hostReady = 0;
    checkOutput("wr_tx_empty", txLevel, 0);

    $display("[TB] fill TX and overflow write");
    for (int i = 0; i < TXD; i++) busWrite(8'(i + 1));
    repeat (PC + 2) nextCycle();
    checkOutput("full_txe_n", txeN, 1'b1);
    checkOutput("full_tx_level", txLevel, 16);
    checkOutput("full_err_before", protoErr, 1'b0);
    tbBusData = 8'hEE;
    wrN = 0;
    nextCycle();
    wrN = 1;
    checkOutput("full_err_set", protoErr, 1'b1);
    checkOutput("full_tx_kept", txLevel, 16);
    nextCycle();
    errClr = 1;
    nextCycle();
    errClr = 0;
    checkOutput("full_err_clr", protoErr, 1'b0);

    $display("[TB] simultaneous read and write strobes");
    hostReady = 1;
    repeat (18) nextCycle();
    hostReady = 0;
    checkOutput("drain_tx", txLevel, 0);
    busWrite(8'h11);
    pushHost(8'h7E);
    waitRxfLow();
    waitTxeLow();
    rdN = 0;
    wrN = 0;
    nextCycle();
    wrN = 1;
    checkOutput("sim_err", protoErr, 1'b1);
    checkOutput("sim_tx_level", txLevel, 1);
    repeat (4) nextCycle();
    rdN = 1;
    nextCycle();
    checkOutput("sim_rx_level", rxLevel, 0);
    checkOutput("sim_tx_after", txLevel, 1);
    errClr = 1;
    nextCycle();
    errClr = 0;

    $display("[TB] reset during read drive");
    pushHost(8'h42);
    waitRxfLow();
    rdN = 0;
    repeat (RD + 1) nextCycle();
    checkOutput("mid_bus_drive", ftdiBus, 8'h42);
    rstN = 0;
    #1;
    checkOutput("mid_bus_release", ftdiBus, 8'hFF);
    checkOutput("mid_rx_level", rxLevel, 0);
    rdN = 1;
    nextCycle();
    rstN = 1;
    nextCycle();
    checkOutput("mid_txe_n", txeN, 1'b0);
`endif

    $display("[TB] randomized traffic");
    applyStimulus(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
